// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//   Shared types and constants for the EX-stage branch resolution logic.
//   - br_type_t : branch class decoded upstream (NONE, B, BR, CBZ, CBNZ, BCOND)
//   - cond_t    : B.cond condition codes, EQ=0 ... NV=15
//   - state_t   : redirect/squash FSM states (RUN, REDIRECT, SQUASH)
//   - FLAG_*    : bit positions of N, Z, C, V inside the {N,Z,C,V} flag word
// ---------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_BR    = 3'd2,
    BR_CBZ   = 3'd3,
    BR_CBNZ  = 3'd4,
    BR_BCOND = 3'd5
  } br_type_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_HS = 4'd2,  COND_LO = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_t;

  // Plain constants rather than an enum so the encoding stays visible to
  // older tools and waveform viewers.
  typedef logic [1:0] state_t;
  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_REDIRECT = 2'd1;
  localparam state_t ST_SQUASH   = 2'd2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
//   Combinational evaluation of a B.cond condition code against NZCV.
//   Ports:
//     i_cond  [3:0]  condition code (cond_t encoding)
//     i_nzcv  [3:0]  flag word {N,Z,C,V}
//     o_pass         1 when the condition holds
// ---------------------------------------------------------------------------
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;
  logic w_base;

  assign w_n = i_nzcv[FLAG_N];
  assign w_z = i_nzcv[FLAG_Z];
  assign w_c = i_nzcv[FLAG_C];
  assign w_v = i_nzcv[FLAG_V];

  // Codes come in complementary pairs: cond[3:1] picks the base test and
  // cond[0] inverts it. AL/NV is the one pair where both codes pass.
  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    w_base = 1'b1;
    unique case (i_cond[3:1])
      3'd0: w_base = w_z;
      3'd1: w_base = w_c;
      3'd2: w_base = w_n;
      3'd3: w_base = w_v;
      3'd4: w_base = w_c & ~w_z;
      3'd5: w_base = (w_n == w_v);
      3'd6: w_base = ~w_z & (w_n == w_v);
      3'd7: w_base = 1'b1;
      default: w_base = 1'b1;
    endcase
  end

  assign o_pass = (i_cond[3:1] == 3'd7) ? 1'b1 : (w_base ^ i_cond[0]);

endmodule

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//   EX-stage branch resolution for the LEGv8 pipeline. Holds the NZCV flag
//   register, decides B/BR/CBZ/CBNZ/B.cond, issues a registered one-cycle
//   fetch redirect followed by a fixed wrong-path squash window, and keeps a
//   saturating count of taken branches.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     ex_valid, ex_stall         EX instruction present / frozen this cycle
//     set_flags                  instruction writes NZCV
//     is_zero, alu_negative,
//     alu_carry, alu_overflow    ALU status (Z, N, C, V)
//     br_type [2:0], cond [3:0]  branch class and B.cond code
//     pc, br_offset, reg_target  PC, word offset (unshifted), BR register
//     flags_q [3:0]              committed {N,Z,C,V}
//     redirect, redirect_pc      one-cycle fetch redirect and its target
//     squash                     kill wrong-path instructions in IF/ID/EX
//     taken_count                saturating taken-branch count
// ---------------------------------------------------------------------------
module branch_resolve
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int SQUASH_CYCLES = 2,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ex_valid,
  input  logic                   ex_stall,
  input  logic                   set_flags,
  input  logic                   is_zero,
  input  logic                   alu_negative,
  input  logic                   alu_carry,
  input  logic                   alu_overflow,
  input  logic [2:0]             br_type,
  input  logic [3:0]             cond,
  input  logic [DATA_WIDTH-1:0]  pc,
  input  logic [DATA_WIDTH-1:0]  br_offset,
  input  logic [DATA_WIDTH-1:0]  reg_target,
  output logic [3:0]             flags_q,
  output logic                   redirect,
  output logic [DATA_WIDTH-1:0]  redirect_pc,
  output logic                   squash,
  output logic [COUNT_WIDTH-1:0] taken_count
);

  // The squash counter only has to hold SQUASH_CYCLES-2.
  localparam int CNT_W = (SQUASH_CYCLES > 2) ? $clog2(SQUASH_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((SQUASH_CYCLES > 1) ? (SQUASH_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic                  w_accept;
  logic                  w_cond_pass;
  logic                  w_taken;
  logic [DATA_WIDTH-1:0] w_target;

  // B.cond sees the flags committed before this edge, even when the same
  // instruction also writes new flags.
  branch_cond_eval u_cond_eval (
    .i_cond (cond),
    .i_nzcv (flags_q),
    .o_pass (w_cond_pass)
  );

  assign w_accept = ex_valid & ~ex_stall & (r_state == ST_RUN);

  always_comb begin
    w_taken = 1'b0;
    unique case (br_type)
      BR_B, BR_BR: w_taken = 1'b1;
      BR_CBZ:      w_taken = is_zero;
      BR_CBNZ:     w_taken = ~is_zero;
      BR_BCOND:    w_taken = w_cond_pass;
      default:     w_taken = 1'b0;
    endcase
  end

  // PC-relative target wraps modulo 2^DATA_WIDTH by construction.
  assign w_target = (br_type == BR_BR) ? reg_target : (pc + (br_offset << 2));

  // Outputs are pure decodes of the registered state, so they change only
  // at clock edges.
  assign redirect = (r_state == ST_REDIRECT);
  assign squash   = (r_state != ST_RUN);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      flags_q     <= '0;
      redirect_pc <= '0;
      taken_count <= '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            if (set_flags) begin
              flags_q <= {alu_negative, is_zero, alu_carry, alu_overflow};
            end
            if (w_taken) begin
              r_state     <= ST_REDIRECT;
              redirect_pc <= w_target;
              if (taken_count != '1) begin
                taken_count <= taken_count + COUNT_ONE;
              end
            end
          end
        end
        ST_REDIRECT: begin
          if (SQUASH_CYCLES == 1) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_SQUASH;
            r_cnt   <= CNT_INIT;
          end
        end
        ST_SQUASH: begin
          if (r_cnt == '0) begin
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
//   Directed bench for branch_resolve. The driver issues one vector per cycle
//   and pushes each expected redirect target into a scoreboard queue; a
//   negedge monitor pops and compares whenever the DUT raises redirect, and
//   checks squash, flags and counters against the bench's expectations.
//   A second instance with a 2-bit counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_branch_resolve;
  import branch_pkg::*;

  localparam int DW = 64;
  localparam int SQ = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid, ex_stall, set_flags;
  logic          is_zero, alu_negative, alu_carry, alu_overflow;
  logic [2:0]    br_type;
  logic [3:0]    cond;
  logic [DW-1:0] pc, br_offset, reg_target;

  logic [3:0]    flags_q, s_flags_q;
  logic          redirect, squash, s_redirect, s_squash;
  logic [DW-1:0] redirect_pc, s_redirect_pc;
  logic [CW-1:0] taken_count;
  logic [1:0]    s_taken_count;

  always #5 clk = ~clk;

  branch_resolve #(.DATA_WIDTH(DW), .SQUASH_CYCLES(SQ), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .set_flags(set_flags), .is_zero(is_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .br_type(br_type),
    .cond(cond), .pc(pc), .br_offset(br_offset), .reg_target(reg_target),
    .flags_q(flags_q), .redirect(redirect), .redirect_pc(redirect_pc),
    .squash(squash), .taken_count(taken_count)
  );

  branch_resolve #(.DATA_WIDTH(DW), .SQUASH_CYCLES(SQ), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .set_flags(set_flags), .is_zero(is_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .br_type(br_type),
    .cond(cond), .pc(pc), .br_offset(br_offset), .reg_target(reg_target),
    .flags_q(s_flags_q), .redirect(s_redirect), .redirect_pc(s_redirect_pc),
    .squash(s_squash), .taken_count(s_taken_count)
  );

  typedef struct packed {
    logic          valid;
    logic          stall;
    logic          setf;
    logic [3:0]    nzcv;
    logic [2:0]    bt;
    logic [3:0]    cnd;
    logic [DW-1:0] pc;
    logic [DW-1:0] off;
    logic [DW-1:0] tgt;
  } vec_t;

  // Bench-side expectations, written by the driver just after each edge and
  // read by the monitor on the following negedge.
  logic [3:0]    exp_flags;
  logic [CW-1:0] exp_count;
  logic [1:0]    exp_sat;
  int            squash_left;
  logic          exp_redirect;
  logic [DW-1:0] sb_q[$];
  bit            mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference condition table, one explicit entry per code.
  function automatic logic cond_ref(input int c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cy;
      3:  return !cy;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cy && !z;
      9:  return !(cy && !z);
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  function automatic vec_t mkv(input logic valid, input logic stall,
                               input logic setf, input logic [3:0] nzcv,
                               input logic [2:0] bt, input logic [3:0] cnd,
                               input logic [DW-1:0] p, input logic [DW-1:0] o,
                               input logic [DW-1:0] t);
    vec_t v;
    v.valid = valid; v.stall = stall; v.setf = setf; v.nzcv = nzcv;
    v.bt = bt; v.cnd = cnd; v.pc = p; v.off = o; v.tgt = t;
    return v;
  endfunction

  function automatic vec_t idle_v();
    return mkv(1'b0, 1'b0, 1'b0, 4'h0, BR_NONE, 4'h0, '0, '0, '0);
  endfunction

  // Present one vector for one cycle and advance the expectations.
  task automatic step(input vec_t v, input logic exp_taken,
                      input logic [DW-1:0] exp_tgt);
    logic acc, rst_now;
    ex_valid     = v.valid;
    ex_stall     = v.stall;
    set_flags    = v.setf;
    alu_negative = v.nzcv[3];
    is_zero      = v.nzcv[2];
    alu_carry    = v.nzcv[1];
    alu_overflow = v.nzcv[0];
    br_type      = v.bt;
    cond         = v.cnd;
    pc           = v.pc;
    br_offset    = v.off;
    reg_target   = v.tgt;
    rst_now      = reset;
    acc          = v.valid && !v.stall && (squash_left == 0);
    @(posedge clk);
    #1;
    exp_redirect = 1'b0;
    if (rst_now) begin
      exp_flags   = '0;
      exp_count   = '0;
      exp_sat     = '0;
      squash_left = 0;
    end else if (acc) begin
      if (v.setf) exp_flags = v.nzcv;
      if (exp_taken) begin
        sb_q.push_back(exp_tgt);
        exp_count    = exp_count + 1;
        exp_sat      = (exp_sat == 2'b11) ? 2'b11 : exp_sat + 2'd1;
        squash_left  = SQ;
        exp_redirect = 1'b1;
      end
    end else if (squash_left > 0) begin
      squash_left--;
    end
  endtask

  task automatic drain();
    while (squash_left > 0) step(idle_v(), 1'b0, '0);
  endtask

  // Monitor: compares on every negedge, pops the scoreboard on redirect.
  always @(negedge clk) begin
    if (mon_en) begin
      check("redirect", 64'(redirect), 64'(exp_redirect));
      check("squash", 64'(squash), 64'(squash_left > 0));
      check("flags_q", 64'(flags_q), 64'(exp_flags));
      check("taken_count", 64'(taken_count), 64'(exp_count));
      check("sat_redirect", 64'(s_redirect), 64'(exp_redirect));
      check("sat_squash", 64'(s_squash), 64'(squash_left > 0));
      check("sat_taken_count", 64'(s_taken_count), 64'(exp_sat));
      if (redirect) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL redirect_pc: redirect with no expected target, got 0x%0h",
                   redirect_pc);
        end else begin
          check("redirect_pc", redirect_pc, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] p;
    exp_flags = '0; exp_count = '0; exp_sat = '0;
    squash_left = 0; exp_redirect = 1'b0;

    reset = 1'b1;
    step(idle_v(), 1'b0, '0);
    mon_en = 1'b1;
    step(idle_v(), 1'b0, '0);
    reset = 1'b0;
    check("reset_flags", 64'(flags_q), 64'h0);
    check("reset_count", 64'(taken_count), 64'h0);

    // 1: SUBS 5-5 then B.EQ
    step(mkv(1, 0, 1, 4'b0110, BR_NONE, 4'h0, '0, '0, '0), 1'b0, '0);
    check("t1_flags", 64'(flags_q), 64'h6);
    step(mkv(1, 0, 0, 4'b0000, BR_BCOND, COND_EQ, 64'h100, 64'd4, '0), 1'b1, 64'h110);
    drain();

    // 2: CBNZ not taken, CBZ taken with negative offset
    step(mkv(1, 0, 0, 4'b0100, BR_CBNZ, 4'h0, 64'h200, -64'sd2, '0), 1'b0, '0);
    step(mkv(1, 0, 0, 4'b0100, BR_CBZ, 4'h0, 64'h200, -64'sd2, '0), 1'b1, 64'h1F8);
    drain();

    // 3: stalled branch, released after three cycles
    for (int i = 0; i < 3; i++)
      step(mkv(1, 1, 0, 4'b0000, BR_B, 4'h0, 64'h300, 64'd8, '0), 1'b1, 64'h320);
    step(mkv(1, 0, 0, 4'b0000, BR_B, 4'h0, 64'h300, 64'd8, '0), 1'b1, 64'h320);
    drain();

    // 4: B + set_flags presented during the squash window is ignored
    step(mkv(1, 0, 0, 4'b0000, BR_BR, 4'h0, 64'h400, 64'd1, 64'h4000), 1'b1, 64'h4000);
    for (int i = 0; i < SQ; i++)
      step(mkv(1, 0, 1, 4'b1001, BR_B, 4'h0, 64'h500, 64'd0, '0), 1'b1, 64'h500);
    check("t4_flags", 64'(flags_q), 64'h6);
    check("t4_count", 64'(taken_count), 64'd4);

    // 5: every cond code against every NZCV value, plus target wrap
    for (int f = 0; f < 16; f++) begin
      step(mkv(1, 0, 1, 4'(f), BR_NONE, 4'h0, '0, '0, '0), 1'b0, '0);
      for (int c = 0; c < 16; c++) begin
        p = 64'h1000 + 64'(f * 256 + c * 16);
        step(mkv(1, 0, 0, 4'h0, BR_BCOND, 4'(c), p, 64'(c), '0),
             cond_ref(c, 4'(f)), p + 64'(c * 4));
        drain();
      end
    end
    step(mkv(1, 0, 0, 4'h0, BR_B, 4'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, '0), 1'b1, 64'h0);
    drain();

    // 6: reset in the REDIRECT cycle, with a competing taken branch
    step(mkv(1, 0, 1, 4'b1010, BR_NONE, 4'h0, '0, '0, '0), 1'b0, '0);
    step(mkv(1, 0, 0, 4'h0, BR_B, 4'h0, 64'h600, 64'd2, '0), 1'b1, 64'h608);
    reset = 1'b1;
    step(mkv(1, 0, 1, 4'b1111, BR_B, 4'h0, 64'h700, 64'd0, '0), 1'b1, 64'h700);
    reset = 1'b0;
    check("t6_redirect", 64'(redirect), 64'h0);
    check("t6_squash", 64'(squash), 64'h0);
    check("t6_flags", 64'(flags_q), 64'h0);
    check("t6_count", 64'(taken_count), 64'h0);
    check("t6_pc", redirect_pc, 64'h0);
    // Reset priority: the branch in the reset cycle must not fire now either.
    step(idle_v(), 1'b0, '0);
    check("t6_no_late_redirect", 64'(redirect), 64'h0);

    // Saturation: the 2-bit instance stops at all-ones
    for (int i = 0; i < 5; i++) begin
      step(mkv(1, 0, 0, 4'h0, BR_B, 4'h0, 64'h800, 64'(i), '0), 1'b1, 64'h800 + 64'(i * 4));
      drain();
    end
    check("sat_final", 64'(s_taken_count), 64'h3);
    check("count_final", 64'(taken_count), 64'd5);

    step(idle_v(), 1'b0, '0);
    check("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
